// File: rtl/ovc_status_tracker_if.sv
// Bundle between the VC/switch allocator side and one output port's
// OVC status tracker. The master drives grants, sent-flit events and
// downstream credits; the slave (the tracker) returns per-VC status.
interface ovc_status_tracker_if #(
    parameter int V = 4,
    parameter int B = 4
);
    localparam int CW = $clog2(B + 1);

    logic [V-1:0]    ovc_alloc_in;
    logic            flit_sent_in;
    logic [V-1:0]    flit_sent_ovc_in;
    logic            flit_sent_tail_in;
    logic [V-1:0]    credit_in;
    logic [V-1:0]    ovc_avail_out;
    logic [V-1:0]    ovc_not_full_out;
    logic [V*CW-1:0] credit_cnt_out;
    logic [2:0]      error_out;

    modport master (
        output ovc_alloc_in, flit_sent_in, flit_sent_ovc_in, flit_sent_tail_in, credit_in,
        input  ovc_avail_out, ovc_not_full_out, credit_cnt_out, error_out
    );

    modport slave (
        input  ovc_alloc_in, flit_sent_in, flit_sent_ovc_in, flit_sent_tail_in, credit_in,
        output ovc_avail_out, ovc_not_full_out, credit_cnt_out, error_out
    );
endinterface

// File: rtl/ovc_status_tracker.sv
// Per-output-port OVC status tracker: allocation state and downstream
// credit count for every output VC, plus sticky error flags.
// Optional macro PRONOC_OVC_ATOMIC_DRAIN_EN adds a DRAIN state so a VC is
// only re-allocatable once the previous packet is fully credited back.
module ovc_status_tracker #(
    parameter int V = 4,
    parameter int B = 4
) (
    input logic clk,
    input logic reset,
    ovc_status_tracker_if.slave bus
);
    localparam int CW = $clog2(B + 1);
    localparam logic [CW-1:0] FULL = CW'(B);

`ifdef PRONOC_OVC_ATOMIC_DRAIN_EN
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, DRAIN = 2'd2} vc_state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1} vc_state_t;
`endif

    vc_state_t      state_q [V];
    vc_state_t      state_d [V];
    logic [CW-1:0]  cnt_q   [V];
    logic [CW-1:0]  cnt_d   [V];
    logic [2:0]     err_q;
    logic [2:0]     err_d;

    logic [V-1:0]   dec_v;
    logic [V-1:0]   tail_v;
    logic [V-1:0]   drain_v;
    logic           send_bad;
    logic           alloc_bad;

    // True when at most one bit is set.
    function automatic logic at_most_one(input logic [V-1:0] x);
        return (x & (x - V'(1))) == '0;
    endfunction

    assign dec_v     = {V{bus.flit_sent_in}} & bus.flit_sent_ovc_in;
    assign tail_v    = dec_v & {V{bus.flit_sent_tail_in}};
    assign send_bad  = bus.flit_sent_in &&
                       ((bus.flit_sent_ovc_in == '0) || !at_most_one(bus.flit_sent_ovc_in));
    assign alloc_bad = !at_most_one(bus.ovc_alloc_in);

    // Per-VC flag: VC currently waiting for its credits to return.
    always_comb begin
        drain_v = '0;
        for (int i = 0; i < V; i++) begin
`ifdef PRONOC_OVC_ATOMIC_DRAIN_EN
            drain_v[i] = (state_q[i] == DRAIN);
`else
            drain_v[i] = 1'b0;
`endif
        end
    end

    // Next-state, next-count and sticky error computation for all VCs.
    always_comb begin
        err_d = err_q;
        if (send_bad || alloc_bad) err_d[2] = 1'b1;
        for (int i = 0; i < V; i++) begin
            cnt_d[i]   = cnt_q[i];
            state_d[i] = state_q[i];

            // Simultaneous send and credit cancel out.
            if (dec_v[i] && !bus.credit_in[i]) begin
                if (cnt_q[i] == '0) err_d[0] = 1'b1;
                else                cnt_d[i] = cnt_q[i] - CW'(1);
            end else if (bus.credit_in[i] && !dec_v[i]) begin
                if (cnt_q[i] == FULL) err_d[1] = 1'b1;
                else                  cnt_d[i] = cnt_q[i] + CW'(1);
            end

            if ((bus.ovc_alloc_in[i] && state_q[i] != IDLE) ||
                (dec_v[i] && state_q[i] == IDLE && !bus.ovc_alloc_in[i]) ||
                (dec_v[i] && drain_v[i])) begin
                err_d[2] = 1'b1;
            end else if (!send_bad && !alloc_bad) begin
                case (state_q[i])
                    IDLE: begin
                        if (bus.ovc_alloc_in[i]) begin
                            if (tail_v[i]) begin
`ifdef PRONOC_OVC_ATOMIC_DRAIN_EN
                                state_d[i] = (cnt_d[i] == FULL) ? IDLE : DRAIN;
`else
                                state_d[i] = IDLE;
`endif
                            end else begin
                                state_d[i] = ACTIVE;
                            end
                        end
                    end
                    ACTIVE: begin
                        if (tail_v[i]) begin
`ifdef PRONOC_OVC_ATOMIC_DRAIN_EN
                            state_d[i] = (cnt_d[i] == FULL) ? IDLE : DRAIN;
`else
                            state_d[i] = IDLE;
`endif
                        end
                    end
`ifdef PRONOC_OVC_ATOMIC_DRAIN_EN
                    DRAIN: begin
                        if (cnt_d[i] == FULL) state_d[i] = IDLE;
                    end
`endif
                    default: state_d[i] = IDLE;
                endcase
            end
        end
    end

    // State, credit and error registers; reset discards everything at once.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < V; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= FULL;
            end
            err_q <= '0;
        end else begin
            for (int i = 0; i < V; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            err_q <= err_d;
        end
    end

    for (genvar g = 0; g < V; g++) begin : g_out
        assign bus.ovc_avail_out[g]             = (state_q[g] == IDLE);
        assign bus.ovc_not_full_out[g]          = (cnt_q[g] != '0);
        assign bus.credit_cnt_out[g*CW +: CW]   = cnt_q[g];
    end
    assign bus.error_out = err_q;

endmodule

// File: tb/tb_ovc_status_tracker.sv
// Self-checking bench for ovc_status_tracker: directed scenarios with
// literal expectations plus randomized traffic against a packet-level model.
module tb_ovc_status_tracker;
    localparam int V  = 4;
    localparam int B  = 4;
    localparam int CW = $clog2(B + 1);

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;
    bit   chk_en;

    ovc_status_tracker_if #(.V(V), .B(B)) bus ();

    ovc_status_tracker #(.V(V), .B(B)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: packet-level view of each VC.
    int m_cnt   [V];
    bit m_busy  [V];
    bit m_drain [V];
    bit [2:0] m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [CW-1:0] cnt_of(input int i);
        return bus.credit_cnt_out[i*CW +: CW];
    endfunction

    // Model update on every rising edge from the inputs applied that cycle.
    initial begin : model
        int  nc;
        bit  glob, bad, dec, ends_pkt;
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < V; i++) begin
                    m_cnt[i] = B; m_busy[i] = 0; m_drain[i] = 0;
                end
                m_err = 0;
            end else begin
                glob = (bus.flit_sent_in && $countones(bus.flit_sent_ovc_in) != 1) ||
                       ($countones(bus.ovc_alloc_in) > 1);
                if (glob) m_err[2] = 1;
                for (int i = 0; i < V; i++) begin
                    dec = bus.flit_sent_in && bus.flit_sent_ovc_in[i];
                    nc  = m_cnt[i] - int'(dec) + int'(bus.credit_in[i]);
                    if (nc < 0) begin nc = 0; m_err[0] = 1; end
                    if (nc > B) begin nc = B; m_err[1] = 1; end
                    bad = (bus.ovc_alloc_in[i] && (m_busy[i] || m_drain[i])) ||
                          (dec && !m_busy[i] && !m_drain[i] && !bus.ovc_alloc_in[i]) ||
                          (dec && m_drain[i]);
                    if (bad) m_err[2] = 1;
                    else if (!glob) begin
                        ends_pkt = dec && bus.flit_sent_tail_in && (m_busy[i] || bus.ovc_alloc_in[i]);
                        if (m_drain[i] && nc == B) m_drain[i] = 0;
                        if (bus.ovc_alloc_in[i]) m_busy[i] = 1;
                        if (ends_pkt) begin
                            m_busy[i] = 0;
`ifdef PRONOC_OVC_ATOMIC_DRAIN_EN
                            m_drain[i] = (nc != B);
`endif
                        end
                    end
                    m_cnt[i] = nc;
                end
            end
        end
    end

    // Compare all outputs against the model on every falling edge.
    always @(negedge clk) begin
        logic [V-1:0]    e_avail, e_nf;
        logic [V*CW-1:0] e_cnt;
        if (chk_en) begin
            for (int i = 0; i < V; i++) begin
                e_avail[i] = !m_busy[i] && !m_drain[i];
                e_nf[i]    = (m_cnt[i] != 0);
                e_cnt[i*CW +: CW] = CW'(m_cnt[i]);
            end
            chk("avail", 32'(bus.ovc_avail_out), 32'(e_avail));
            chk("not_full", 32'(bus.ovc_not_full_out), 32'(e_nf));
            chk("credit_cnt", 32'(bus.credit_cnt_out), 32'(e_cnt));
            chk("error", 32'(bus.error_out), 32'(m_err));
        end
    end

    task automatic drive(input logic [V-1:0] a, input logic s, input logic [V-1:0] o,
                         input logic t, input logic [V-1:0] c);
        bus.ovc_alloc_in      = a;
        bus.flit_sent_in      = s;
        bus.flit_sent_ovc_in  = o;
        bus.flit_sent_tail_in = t;
        bus.credit_in         = c;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive('0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic rand_cycle(input bit wild);
        logic [V-1:0] a, o, c;
        logic s, t;
        int v;
        a = '0; o = '0; c = '0; s = 1'b0; t = 1'b0;
        v = $urandom_range(0, V-1);
        if (!m_busy[v] && !m_drain[v] && $urandom_range(0, 2) == 0) a[v] = 1'b1;
        v = $urandom_range(0, V-1);
        if ((m_busy[v] || a[v]) && m_cnt[v] != 0 && $urandom_range(0, 1) == 1) begin
            s = 1'b1; o[v] = 1'b1; t = ($urandom_range(0, 3) == 0);
        end
        for (int i = 0; i < V; i++)
            if (m_cnt[i] < B && $urandom_range(0, 2) == 0) c[i] = 1'b1;
        if (wild && $urandom_range(0, 7) == 0) begin
            a = V'($urandom); s = 1'($urandom); o = V'($urandom);
            t = 1'($urandom); c = V'($urandom);
        end
        drive(a, s, o, t, c);
    endtask

    localparam logic [V*CW-1:0] ALL_FULL = {V{CW'(B)}};

    initial begin
        n_checks = 0; n_pass = 0; chk_en = 0;
        reset = 1'b1;
        bus.ovc_alloc_in = '0; bus.flit_sent_in = 1'b0; bus.flit_sent_ovc_in = '0;
        bus.flit_sent_tail_in = 1'b0; bus.credit_in = '0;
        @(negedge clk);
        chk_en = 1;
        @(negedge clk);
        reset = 1'b0;

        // 1: reset state holds while idle
        idle(3);
        chk("rst_avail", 32'(bus.ovc_avail_out), 32'hf);
        chk("rst_nf", 32'(bus.ovc_not_full_out), 32'hf);
        chk("rst_cnt", 32'(bus.credit_cnt_out), 32'(ALL_FULL));
        chk("rst_err", 32'(bus.error_out), 32'h0);

        // 2: four-flit packet on VC1, no credits back
        drive(4'b0010, 1'b0, '0, 1'b0, '0);
        chk("alloc_vc1_busy", 32'(bus.ovc_avail_out[1]), 32'h0);
        for (int k = 0; k < 4; k++) drive('0, 1'b1, 4'b0010, (k == 3), '0);
        chk("vc1_cnt0", 32'(cnt_of(1)), 32'h0);
        chk("vc1_full", 32'(bus.ovc_not_full_out[1]), 32'h0);
`ifdef PRONOC_OVC_ATOMIC_DRAIN_EN
        chk("vc1_drain", 32'(bus.ovc_avail_out[1]), 32'h0);
        for (int k = 0; k < 3; k++) drive('0, 1'b0, '0, 1'b0, 4'b0010);
        chk("vc1_drain3", 32'(bus.ovc_avail_out[1]), 32'h0);
        drive('0, 1'b0, '0, 1'b0, 4'b0010);
        chk("vc1_drained", 32'(bus.ovc_avail_out[1]), 32'h1);
`else
        chk("vc1_idle", 32'(bus.ovc_avail_out[1]), 32'h1);
        for (int k = 0; k < 4; k++) drive('0, 1'b0, '0, 1'b0, 4'b0010);
`endif
        chk("vc1_cnt4", 32'(cnt_of(1)), 32'h4);

        // 3: simultaneous send and credit keep the count
        drive(4'b0100, 1'b1, 4'b0100, 1'b0, '0);
        drive('0, 1'b1, 4'b0100, 1'b0, '0);
        chk("vc2_cnt2", 32'(cnt_of(2)), 32'h2);
        for (int k = 0; k < 5; k++) drive('0, 1'b1, 4'b0100, 1'b0, 4'b0100);
        chk("vc2_hold", 32'(cnt_of(2)), 32'h2);
        chk("vc2_err", 32'(bus.error_out), 32'h0);
        drive('0, 1'b1, 4'b0100, 1'b1, '0);
        for (int k = 0; k < 3; k++) drive('0, 1'b0, '0, 1'b0, 4'b0100);
        chk("vc2_back", 32'(bus.ovc_avail_out[2]), 32'h1);

        // 4: single-flit packet granted and sent together
        drive(4'b0001, 1'b1, 4'b0001, 1'b1, '0);
        chk("vc0_cnt3", 32'(cnt_of(0)), 32'h3);
`ifdef PRONOC_OVC_ATOMIC_DRAIN_EN
        chk("vc0_avail", 32'(bus.ovc_avail_out[0]), 32'h0);
`else
        chk("vc0_avail", 32'(bus.ovc_avail_out[0]), 32'h1);
`endif
        drive('0, 1'b0, '0, 1'b0, 4'b0001);

        // 5: protocol violation and credit overflow, both sticky
        drive('0, 1'b1, 4'b1000, 1'b0, '0);
        chk("viol_err", 32'(bus.error_out), 32'h4);
        chk("viol_cnt3", 32'(cnt_of(3)), 32'h3);
        drive('0, 1'b0, '0, 1'b0, 4'b0001);
        chk("ovf_err", 32'(bus.error_out), 32'h6);
        chk("ovf_cnt4", 32'(cnt_of(0)), 32'h4);
        drive('0, 1'b0, '0, 1'b0, 4'b1000);
        idle(2);
        chk("sticky_err", 32'(bus.error_out), 32'h6);

        // 6: reset in the middle of a drain
        drive(4'b0010, 1'b0, '0, 1'b0, '0);
        for (int k = 0; k < 4; k++) drive('0, 1'b1, 4'b0010, (k == 3), '0);
        drive('0, 1'b0, '0, 1'b0, 4'b0010);
        chk("pre_rst_cnt1", 32'(cnt_of(1)), 32'h1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        chk("mid_rst_avail", 32'(bus.ovc_avail_out), 32'hf);
        chk("mid_rst_cnt", 32'(bus.credit_cnt_out), 32'(ALL_FULL));
        chk("mid_rst_err", 32'(bus.error_out), 32'h0);

        // Randomized legal traffic, then traffic with injected faults
        for (int k = 0; k < 600; k++) rand_cycle(1'b0);
        chk("legal_err", 32'(bus.error_out), 32'h0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        for (int k = 0; k < 600; k++) rand_cycle(1'b1);
        idle(3);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ovc_status_tracker.md
Name: ovc_status_tracker

Overview:
- Output-port-side companion of the combined VC/switch allocator.
- Tracks, per output VC of one router output port, the allocation state and the downstream credit count.
- Consumes OVC grants, forwarded-flit events and downstream credit returns.
- Produces the OVC-available mask and OVC-not-full flags that the input ports use to build masked OVC requests and assigned-OVC-not-full indications.
- One instance per output port.

Parameters:
- V, 4, number of virtual channels per port (≥1).
- B, 4, downstream buffer depth per VC in flits (≥2).
- CW, $clog2(B+1), credit counter width (derived localparam, not overridable).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- ovc_alloc_in  input  V  one-hot (or zero) OVC granted by the allocator this cycle.
- flit_sent_in  input  1  a flit leaves through this output port this cycle.
- flit_sent_ovc_in  input  V  one-hot OVC of the sent flit; valid only when flit_sent_in=1.
- flit_sent_tail_in  input  1  the sent flit is a tail flit, or a single-flit packet.
- credit_in  input  V  per-VC credit return from downstream; at most one per VC per cycle.
- ovc_avail_out  output  V  1 = VC is in IDLE and may be allocated.
- ovc_not_full_out  output  V  1 = credit count ≠ 0.
- credit_cnt_out  output  V*CW  per-VC credit counts; VC i occupies bits [i*CW +: CW].
- error_out  output  3  sticky flags: [0] credit underflow, [1] credit overflow, [2] protocol violation.

Behaviour:

Reset:
- All VCs go to IDLE.
- Credit counts = B.
- ovc_avail_out = all 1s.
- ovc_not_full_out = all 1s.
- error_out = 0.
- Reset mid-packet discards all state in the same cycle; there is no drain.

Timing:
- All state is registered and all outputs are driven directly from registers.
- An event at edge t is visible on the outputs after edge t.
- There are no combinational paths from inputs to outputs.

Credit counter, per VC:
- dec = flit_sent_in & flit_sent_ovc_in[i]
- inc = credit_in[i]
- Both set: count unchanged.
- dec only: count − 1. If count is 0, hold at 0 and set error_out[0].
- inc only: count + 1. If count is B, hold at B and set error_out[1].

Per-VC state machine:
- IDLE → ACTIVE on ovc_alloc_in[i].
- IDLE → (tail handling) when ovc_alloc_in[i] and a tail is sent on VC i in the same cycle (single-flit packet granted and forwarded together).
- ACTIVE → (tail handling) when a tail is sent on VC i.
- Tail handling, without the optional feature: go to IDLE.
- Tail handling, with the optional feature: go to DRAIN.
- DRAIN → IDLE in the cycle the next-state count equals B.
- If the count is already B when the tail is sent (credit returned the same cycle), go straight to IDLE.

Protocol violations (set error_out[2], state unchanged):
- ovc_alloc_in[i] while VC i is ACTIVE or DRAIN.
- A flit sent on VC i while VC i is IDLE and not being allocated in the same cycle.
- A flit sent on VC i while VC i is in DRAIN.
- flit_sent_ovc_in not one-hot while flit_sent_in=1.
- ovc_alloc_in not one-hot and not zero.

Protocol-violation events still update the credit counters. Credits are counted in every state.

Outputs:
- ovc_avail_out[i] = (state == IDLE).
- ovc_not_full_out[i] = (count_q ≠ 0).
- The upstream sender issues at most one flit per VC per cycle, so the registered count never lags a send.

Optional Feature:
PRONOC_OVC_ATOMIC_DRAIN_EN
- Defined: the DRAIN state exists. A VC is re-allocatable only after every flit of the previous packet has been credited back (atomic VC reallocation).
- Undefined: the DRAIN state is not synthesized. A VC returns to IDLE the cycle after its tail is sent, and the next packet may share the downstream buffer (non-atomic).

Test Plan:
1. Reset, then idle 3 cycles → ovc_avail_out = 4'b1111, ovc_not_full_out = 4'b1111, every count = 4, error_out = 0.
2. Allocate VC1; send 4 flits on VC1 (4th is tail); no credits returned.
   - Count for VC1 goes 4→0; ovc_not_full_out[1] = 0 after the 4th send.
   - Feature off: ovc_avail_out[1] = 1 one cycle after the tail.
   - Feature on: ovc_avail_out[1] stays 0 until 4 credits arrive, and rises the cycle after the 4th credit.
3. VC2 at count 2: apply send + credit together for 5 cycles → count stays 2; error_out = 0.
4. Single-flit packet: ovc_alloc_in = 4'b0001 together with a tail send on VC0 → VC0 is never seen unavailable (feature off); count for VC0 = 3.
5. Send on IDLE VC3 without allocation → error_out[2] = 1 and count = 3. Credit to VC0 at count 4 → error_out[1] = 1 and count stays 4. Both flags hold until reset.
6. Reset asserted while VC1 is in DRAIN with count 1 → the next cycle shows all VCs IDLE, all counts 4, error_out = 0.
